// File: rtl/spectag_allocator_pkg.sv
// Shared widths and reset values for the speculative-tag allocator slice.
package spectag_allocator_pkg;

  localparam int SPECTAG_LEN = 5;
  localparam int BRDEPTH_LEN = 3;

  typedef logic [SPECTAG_LEN-1:0] spectag_t;
  typedef logic [BRDEPTH_LEN-1:0] brdepth_t;

  localparam spectag_t SPECTAG_INIT = 5'b00001;
  localparam brdepth_t MAX_DEPTH    = 3'd5;

endpackage

// File: rtl/spectag_allocator_rotl.sv
// One-hot rotate-left by one position; the top bit wraps to bit 0.
module spectag_rotl
  import spectag_allocator_pkg::*;
(
  input  logic [SPECTAG_LEN-1:0] i_tag,
  output logic [SPECTAG_LEN-1:0] o_tag
);

  assign o_tag = {i_tag[SPECTAG_LEN-2:0], i_tag[SPECTAG_LEN-1]};

endmodule

// File: rtl/spectag_allocator.sv
// Hands out up to two one-hot branch tags per cycle in ring order and tracks
// the in-flight tag mask; the mask mirrors the fix table's valid bits.
module spectag_allocator
  import spectag_allocator_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst1_isbranch,
  input  logic                   inst2_isbranch,
  input  logic                   inst1_inv,
  input  logic                   inst2_inv,
  input  logic                   stall_in,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic [SPECTAG_LEN-1:0] inst1_spectag,
  output logic [SPECTAG_LEN-1:0] inst2_spectag,
  output logic [SPECTAG_LEN-1:0] setspec1_tag,
  output logic [SPECTAG_LEN-1:0] setspec2_tag,
  output logic                   setspec1_en,
  output logic                   setspec2_en,
  output logic                   alloc_stall,
  output logic [SPECTAG_LEN-1:0] spec_valid,
  output logic [BRDEPTH_LEN-1:0] brdepth
);

  spectag_t r_cur_tag;
  spectag_t r_spec_valid;
  brdepth_t r_brdepth;

  spectag_t w_tag_a;
  spectag_t w_tag_b;
  logic     w_b1;
  logic     w_b2;
  brdepth_t w_need;
  brdepth_t w_free;
  logic     w_go;
  spectag_t w_newest;
  spectag_t w_spec_next;
  brdepth_t w_brdepth_next;

  spectag_rotl u_rotl_a (.i_tag(r_cur_tag), .o_tag(w_tag_a));
  spectag_rotl u_rotl_b (.i_tag(w_tag_a),   .o_tag(w_tag_b));

  assign w_b1   = inst1_isbranch & ~inst1_inv;
  assign w_b2   = inst2_isbranch & ~inst2_inv;
  assign w_need = {2'b00, w_b1} + {2'b00, w_b2};
  assign w_free = MAX_DEPTH - r_brdepth;

  // Capacity uses registered depth only; a same-cycle prsuccess is not bypassed.
  assign alloc_stall = (w_need > w_free);
  assign w_go        = ~stall_in & ~alloc_stall & ~prmiss;

  assign inst1_spectag = w_b1 ? w_tag_a : r_cur_tag;
  assign inst2_spectag = w_b2 ? (w_b1 ? w_tag_b : w_tag_a) : (w_b1 ? w_tag_a : r_cur_tag);
  assign setspec1_tag  = w_tag_a;
  assign setspec2_tag  = w_b1 ? w_tag_b : w_tag_a;
  assign setspec1_en   = w_go & w_b1;
  assign setspec2_en   = w_go & w_b2;

  assign w_newest       = w_b2 ? setspec2_tag : w_tag_a;
  assign w_spec_next    = (r_spec_valid & ~(prsuccess ? prtag : '0))
                        | (setspec1_en ? setspec1_tag : '0)
                        | (setspec2_en ? setspec2_tag : '0);
  assign w_brdepth_next = r_brdepth - {2'b00, prsuccess} + (w_go ? w_need : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_tag    <= SPECTAG_INIT;
      r_spec_valid <= '0;
      r_brdepth    <= '0;
    end else if (prmiss) begin
      r_cur_tag    <= prtag;
      r_spec_valid <= '0;
      r_brdepth    <= '0;
    end else begin
      r_spec_valid <= w_spec_next;
      r_brdepth    <= w_brdepth_next;
      if (w_go & (w_b1 | w_b2))
        r_cur_tag <= w_newest;
    end
  end

  assign spec_valid = r_spec_valid;
  assign brdepth    = r_brdepth;

  // Resolution events must name exactly one live tag, one event at a time.
  a_event_exclusive: assert property (@(posedge clk) disable iff (reset) !(prmiss && prsuccess));
  a_prtag_onehot:    assert property (@(posedge clk) disable iff (reset) (prmiss || prsuccess) |-> $onehot(prtag));
  a_success_live:    assert property (@(posedge clk) disable iff (reset) prsuccess |-> ((prtag & r_spec_valid) != '0));
  a_success_depth:   assert property (@(posedge clk) disable iff (reset) prsuccess |-> (r_brdepth != '0));

endmodule

// File: tb/tb_spectag_allocator.sv
// Directed vector table, a mid-operation reset sequence, then random traffic
// compared against a queue-of-tag-indices model of the allocator.
module tb_spectag_allocator;

  logic       clk;
  logic       reset;
  logic       inst1_isbranch, inst2_isbranch, inst1_inv, inst2_inv;
  logic       stall_in, prmiss, prsuccess;
  logic [4:0] prtag;
  logic [4:0] inst1_spectag, inst2_spectag, setspec1_tag, setspec2_tag;
  logic       setspec1_en, setspec2_en, alloc_stall;
  logic [4:0] spec_valid;
  logic [2:0] brdepth;

  int nVectors     = 0;
  int nChecks      = 0;
  int nMiscompares = 0;

  spectag_allocator dut (
    .clk(clk), .reset(reset),
    .inst1_isbranch(inst1_isbranch), .inst2_isbranch(inst2_isbranch),
    .inst1_inv(inst1_inv), .inst2_inv(inst2_inv),
    .stall_in(stall_in), .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
    .inst1_spectag(inst1_spectag), .inst2_spectag(inst2_spectag),
    .setspec1_tag(setspec1_tag), .setspec2_tag(setspec2_tag),
    .setspec1_en(setspec1_en), .setspec2_en(setspec2_en),
    .alloc_stall(alloc_stall), .spec_valid(spec_valid), .brdepth(brdepth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       isb1, inv1, isb2, inv2, stall, miss, succ;
    logic [4:0] tag;
    logic [4:0] i1, i2, s1;
    logic       s1en;
    logic [4:0] s2;
    logic       s2en, ast;
    logic [4:0] sv;
    logic [2:0] bd;
  } vec_t;

  vec_t tbl[$];

  int         mCur;
  int         mQ[$];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic isb1, input logic inv1, input logic isb2, input logic inv2,
                               input logic stall, input logic miss, input logic succ, input logic [4:0] tag);
    inst1_isbranch = isb1; inst1_inv = inv1;
    inst2_isbranch = isb2; inst2_inv = inv2;
    stall_in = stall; prmiss = miss; prsuccess = succ; prtag = tag;
    nVectors++;
  endtask

  function automatic logic [4:0] oh(input int idx);
    logic [4:0] one;
    one = 5'b00001;
    return one << idx;
  endfunction

  function automatic logic [4:0] modelMask();
    logic [4:0] m;
    m = '0;
    foreach (mQ[k]) m |= oh(mQ[k]);
    return m;
  endfunction

  initial begin
    vec_t v;
    int   b1, b2, need, t, eI1, eI2, eS1, eS2, tagIdx, ev;
    logic eAst, eGo, doReset, r1, r2, r3, r4, rs, rm, rsu;

    // isb1 inv1 isb2 inv2 stall miss succ tag | i1 i2 s1 s1en s2 s2en ast | sv bd
    tbl.push_back('{1,0,0,0,0,0,0,5'b00001, 5'b00010,5'b00010,5'b00010,1,5'b00100,0,0, 5'b00010,3'd1});
    tbl.push_back('{1,0,1,0,0,0,0,5'b00001, 5'b00100,5'b01000,5'b00100,1,5'b01000,1,0, 5'b01110,3'd3});
    tbl.push_back('{1,0,1,0,0,0,1,5'b00010, 5'b10000,5'b00001,5'b10000,1,5'b00001,1,0, 5'b11101,3'd4});
    tbl.push_back('{1,0,1,0,0,0,1,5'b00100, 5'b00010,5'b00100,5'b00010,0,5'b00100,0,1, 5'b11001,3'd3});
    tbl.push_back('{1,0,1,0,0,0,0,5'b00001, 5'b00010,5'b00100,5'b00010,1,5'b00100,1,0, 5'b11111,3'd5});
    tbl.push_back('{1,1,1,0,0,0,1,5'b01000, 5'b00100,5'b01000,5'b01000,0,5'b01000,0,1, 5'b10111,3'd4});
    tbl.push_back('{1,0,0,0,0,0,1,5'b10000, 5'b01000,5'b01000,5'b01000,1,5'b10000,0,0, 5'b01111,3'd4});
    tbl.push_back('{0,0,1,0,1,0,0,5'b00001, 5'b01000,5'b10000,5'b10000,0,5'b10000,0,0, 5'b01111,3'd4});
    tbl.push_back('{0,0,1,0,0,0,0,5'b00001, 5'b01000,5'b10000,5'b10000,0,5'b10000,1,0, 5'b11111,3'd5});
    tbl.push_back('{0,0,0,0,0,0,1,5'b00001, 5'b10000,5'b10000,5'b00001,0,5'b00001,0,0, 5'b11110,3'd4});
    tbl.push_back('{1,0,0,0,0,1,0,5'b00100, 5'b00001,5'b00001,5'b00001,0,5'b00010,0,0, 5'b00000,3'd0});
    tbl.push_back('{1,0,0,0,0,0,0,5'b00001, 5'b01000,5'b01000,5'b01000,1,5'b10000,0,0, 5'b01000,3'd1});
    tbl.push_back('{1,1,1,1,0,0,0,5'b00001, 5'b01000,5'b01000,5'b10000,0,5'b10000,0,0, 5'b01000,3'd1});

    reset = 1'b1;
    applyStimulus(0,0,0,0,0,0,0,5'b00001);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_spec_valid", 8'(spec_valid), 8'h00);
    checkOutput("reset_brdepth", 8'(brdepth), 8'h00);
    @(negedge clk);
    checkOutput("reset_inst1_spectag", 8'(inst1_spectag), 8'h01);
    checkOutput("reset_setspec1_tag", 8'(setspec1_tag), 8'h02);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      applyStimulus(v.isb1, v.inv1, v.isb2, v.inv2, v.stall, v.miss, v.succ, v.tag);
      @(negedge clk);
      checkOutput($sformatf("v%0d_inst1_spectag", i), 8'(inst1_spectag), 8'(v.i1));
      checkOutput($sformatf("v%0d_inst2_spectag", i), 8'(inst2_spectag), 8'(v.i2));
      checkOutput($sformatf("v%0d_setspec1_tag", i), 8'(setspec1_tag), 8'(v.s1));
      checkOutput($sformatf("v%0d_setspec1_en", i), 8'(setspec1_en), 8'(v.s1en));
      checkOutput($sformatf("v%0d_setspec2_tag", i), 8'(setspec2_tag), 8'(v.s2));
      checkOutput($sformatf("v%0d_setspec2_en", i), 8'(setspec2_en), 8'(v.s2en));
      checkOutput($sformatf("v%0d_alloc_stall", i), 8'(alloc_stall), 8'(v.ast));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_spec_valid", i), 8'(spec_valid), 8'(v.sv));
      checkOutput($sformatf("v%0d_brdepth", i), 8'(brdepth), 8'(v.bd));
    end

    // Reset while a branch is presented wins over the allocation.
    reset = 1'b1;
    applyStimulus(1,0,0,0,0,0,0,5'b00001);
    @(posedge clk); #1;
    checkOutput("midreset_spec_valid", 8'(spec_valid), 8'h00);
    checkOutput("midreset_brdepth", 8'(brdepth), 8'h00);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_setspec1_tag", 8'(setspec1_tag), 8'h02);
    checkOutput("midreset_setspec1_en", 8'(setspec1_en), 8'h01);
    @(posedge clk); #1;
    checkOutput("midreset_next_spec_valid", 8'(spec_valid), 8'h02);
    checkOutput("midreset_next_brdepth", 8'(brdepth), 8'h01);

    reset = 1'b1;
    applyStimulus(0,0,0,0,0,0,0,5'b00001);
    @(posedge clk); #1;
    reset = 1'b0;
    mCur = 0;
    mQ.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      r1 = 1'($urandom_range(0, 1));
      r2 = ($urandom_range(0, 3) == 0);
      r3 = 1'($urandom_range(0, 1));
      r4 = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) == 0);
      ev = $urandom_range(0, 9);
      tagIdx = $urandom_range(0, 4);
      rm = 1'b0;
      rsu = 1'b0;
      if (ev == 0) rm = 1'b1;
      else if (ev <= 4 && mQ.size() > 0) begin
        rsu = 1'b1;
        tagIdx = mQ[0];
      end
      doReset = ($urandom_range(0, 99) == 0);
      reset = doReset;
      applyStimulus(r1, r2, r3, r4, rs, rm, rsu, oh(tagIdx));

      b1 = (r1 && !r2) ? 1 : 0;
      b2 = (r3 && !r4) ? 1 : 0;
      t = mCur;
      if (b1 == 1) t = (t + 1) % 5;
      eI1 = t;
      if (b2 == 1) t = (t + 1) % 5;
      eI2 = t;
      eS1 = (mCur + 1) % 5;
      eS2 = (mCur + 1 + b1) % 5;
      need = b1 + b2;
      eAst = (need > 5 - mQ.size());
      eGo = !rs && !eAst && !rm;

      @(negedge clk);
      checkOutput("rnd_inst1_spectag", 8'(inst1_spectag), 8'(oh(eI1)));
      checkOutput("rnd_inst2_spectag", 8'(inst2_spectag), 8'(oh(eI2)));
      checkOutput("rnd_setspec1_tag", 8'(setspec1_tag), 8'(oh(eS1)));
      checkOutput("rnd_setspec2_tag", 8'(setspec2_tag), 8'(oh(eS2)));
      checkOutput("rnd_setspec1_en", 8'(setspec1_en), 8'(eGo && b1 == 1));
      checkOutput("rnd_setspec2_en", 8'(setspec2_en), 8'(eGo && b2 == 1));
      checkOutput("rnd_alloc_stall", 8'(alloc_stall), 8'(eAst));

      if (doReset) begin
        mCur = 0;
        mQ.delete();
      end else if (rm) begin
        mCur = tagIdx;
        mQ.delete();
      end else begin
        if (rsu) void'(mQ.pop_front());
        if (eGo) begin
          if (b1 == 1) mQ.push_back(eS1);
          if (b2 == 1) mQ.push_back(eS2);
          if (need > 0) mCur = eI2;
        end
      end

      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("rnd_spec_valid", 8'(spec_valid), 8'(modelMask()));
      checkOutput("rnd_brdepth", 8'(brdepth), 8'(mQ.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
